serial_word_loader: RTL and testbench
=====================================

Name: serial_word_loader

Overview:
- Controller that sequences the 16-bit serial-in/parallel-out shift register to load program words bit-serially, e.g. Hack ROM image from an external link.
- Gates the register's enable, counts 16 accepted bits per word, presents each completed word with a valid/ready handshake and an incrementing write address.
- Sits between the serial receive front-end and the ROM write port. Does not contain the shift register itself.

Parameters:
- WORD_COUNT, 32768, number of words per load session (1 to 2**ADDR_W).
- ADDR_W, 15, width of addr_o.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- resetb  input  1  synchronous active-low reset.
- start_i  input  1  begin a load session; honoured only in IDLE or DONE.
- abort_i  input  1  synchronous abort; returns to IDLE from any state.
- bit_i  input  1  serial data bit, MSB first.
- bit_valid_i  input  1  one-cycle strobe qualifying bit_i.
- shift_en_o  output  1  drives shift register en_i.
- shift_in_o  output  1  drives shift register in_i.
- sr_word_i  input  16  shift register out_o.
- word_o  output  16  completed word.
- word_valid_o  output  1  word_o/addr_o valid.
- word_ready_i  input  1  consumer accepts the word.
- addr_o  output  ADDR_W  write address of the current word.
- busy_o  output  1  high in SHIFT or PRESENT.
- done_o  output  1  session complete.
- overrun_o  output  1  sticky: bit dropped while not accepting bits.

Behaviour:
- Reset (resetb=0 at a clk edge): state IDLE; bit_cnt=0; addr_o=0; word_valid_o=0; busy_o=0; done_o=0; overrun_o=0. Reset has priority over abort_i and start_i. Reset mid-session discards the partial word.
- FSM states: IDLE, SHIFT, PRESENT, DONE.
- IDLE: start_i -> SHIFT, with addr_o=0, bit_cnt=0, overrun_o cleared.
- SHIFT:
  - shift_en_o = bit_valid_i (combinational); shift_in_o = bit_i. No other state asserts shift_en_o.
  - Each accepted bit increments the 4-bit bit_cnt.
  - On the bit accepted with bit_cnt==15: bit_cnt wraps to 0 and the FSM goes to PRESENT on the next edge.
  - The shift register holds the full word from that edge; the first received bit lands in bit 15.
- PRESENT:
  - word_valid_o=1; word_o=sr_word_i (combinational pass-through, stable because the enable is low); addr_o stable.
  - word_valid_o stays high until word_ready_i is sampled high; it does not depend on word_ready_i.
  - On valid&ready: if addr_o==WORD_COUNT-1, go to DONE with addr_o unchanged. Otherwise increment addr_o and go to SHIFT.
  - A bit_valid_i in PRESENT is dropped and sets overrun_o. A bit arriving on the handshake cycle is also dropped.
- DONE: done_o=1; start_i -> SHIFT, clearing addr_o, bit_cnt and done_o. bit_valid_i here sets overrun_o.
- overrun_o: set by bit_valid_i in IDLE, PRESENT or DONE. Cleared only by reset or session start.
- abort_i: in any state, next state IDLE. bit_cnt=0, addr_o=0, word_valid_o=0, done_o=0; overrun_o held. abort_i wins over start_i and the handshake in the same cycle.
- busy_o = state is SHIFT or PRESENT. Outputs other than shift_en_o, shift_in_o and word_o are registered or derived directly from state.
- Throughput: 16 bit strobes plus 1 handshake cycle per word minimum. Bits may arrive back-to-back every cycle.

Test Plan:
- Reset, start_i, then 16 back-to-back bits of 0xA5C3 MSB first with word_ready_i=1 -> shift_en_o high for exactly 16 cycles; word_valid_o=1 one cycle after the 16th bit with word_o=0xA5C3, addr_o=0; addr_o=1 next cycle in SHIFT.
- WORD_COUNT=3, three words 0x0001/0x8000/0xFFFF with word_ready_i=1 -> addresses 0,1,2 presented; done_o=1 after the third handshake; busy_o=0; addr_o=2.
- Hold word_ready_i=0 for 5 cycles in PRESENT and strobe bit_valid_i once -> word_valid_o held and word_o unchanged; shift_en_o stays 0; overrun_o=1; the word is accepted when ready rises.
- abort_i after 7 bits of a word -> IDLE next cycle, busy_o=0; a new start plus 16 bits of 0x1234 -> word_o=0x1234, addr_o=0.
- resetb=0 in PRESENT with word_valid_o=1 -> all outputs at reset values on the next edge; start_i ignored while resetb=0.
- In DONE, start_i asserted together with bit_valid_i -> overrun_o cleared, done_o=0, addr_o=0; the next 16 bits form word 0.

Source files
------------

// File: rtl/serial_word_loader.sv
// Sequences a 16-bit SIPO shift register to assemble serial words and hands them off with valid/ready and a write address.
// Latency: word presented the cycle after its 16th bit; stalls in PRESENT until accepted; bits arriving outside SHIFT are dropped and flagged.
module serial_word_loader #(
  parameter int WORD_COUNT = 32768,
  parameter int ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              bit_i,
  input  logic              bit_valid_i,
  output logic              shift_en_o,
  output logic              shift_in_o,
  input  logic [15:0]       sr_word_i,
  output logic [15:0]       word_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 1);

  state_t     state;
  logic [3:0] bit_cnt;

  // The register only advances in SHIFT, so its output is stable while a word is presented.
  assign shift_en_o = (state == SHIFT) && bit_valid_i;
  assign shift_in_o = bit_i;
  assign word_o     = sr_word_i;
  assign busy_o     = (state == SHIFT) || (state == PRESENT);

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state        <= IDLE;
      bit_cnt      <= 4'd0;
      addr_o       <= '0;
      word_valid_o <= 1'b0;
      done_o       <= 1'b0;
      overrun_o    <= 1'b0;
    end else if (abort_i) begin
      state        <= IDLE;
      bit_cnt      <= 4'd0;
      addr_o       <= '0;
      word_valid_o <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state     <= SHIFT;
            bit_cnt   <= 4'd0;
            addr_o    <= '0;
            done_o    <= 1'b0;
            overrun_o <= 1'b0;
          end else if (bit_valid_i) begin
            overrun_o <= 1'b1;
          end
        end
        SHIFT: begin
          if (bit_valid_i) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              state        <= PRESENT;
              word_valid_o <= 1'b1;
            end
          end
        end
        PRESENT: begin
          if (bit_valid_i) begin
            overrun_o <= 1'b1;
          end
          if (word_ready_i) begin
            word_valid_o <= 1'b0;
            if (addr_o == LAST_ADDR) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state  <= SHIFT;
              addr_o <= addr_o + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_loader.sv
// Bench for serial_word_loader with a behavioural SIPO register and an expected-word scoreboard.
module tb_serial_word_loader;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          resetb, start_i, abort_i, bit_i, bit_valid_i, word_ready_i;
  logic          shift_en_o, shift_in_o, word_valid_o, busy_o, done_o, overrun_o;
  logic [15:0]   sr_word_i, word_o;
  logic [AW-1:0] addr_o;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   word;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   en_cnt;

  serial_word_loader #(.WORD_COUNT(3), .ADDR_W(AW)) dut (
    .clk(clk), .resetb(resetb), .start_i(start_i), .abort_i(abort_i),
    .bit_i(bit_i), .bit_valid_i(bit_valid_i), .shift_en_o(shift_en_o),
    .shift_in_o(shift_in_o), .sr_word_i(sr_word_i), .word_o(word_o),
    .word_valid_o(word_valid_o), .word_ready_i(word_ready_i), .addr_o(addr_o),
    .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  // Model of the external shift register, MSB first.
  always @(posedge clk) begin
    if (shift_en_o) sr_word_i <= {sr_word_i[14:0], shift_in_o};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetb = 1'b0; start_i = 1'b0; abort_i = 1'b0; bit_i = 1'b0;
    bit_valid_i = 1'b0; word_ready_i = 1'b1;
    tick(); tick();
    resetb = 1'b1;
    sb.delete();
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 15; i > 15 - n; i--) begin
      bit_valid_i = 1'b1;
      bit_i = w[i];
      #1;
      if (shift_en_o) en_cnt++;
      tick();
    end
    bit_valid_i = 1'b0;
    bit_i = 1'b0;
  endtask

  task automatic test_reset();
    sr_word_i = 16'h0;
    do_reset();
    total++;
    if ({word_valid_o, busy_o, done_o, overrun_o, addr_o, shift_en_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got v=%0b b=%0b d=%0b o=%0b a=%0d en=%0b exp all 0",
               word_valid_o, busy_o, done_o, overrun_o, addr_o, shift_en_o);
    end
  endtask

  task automatic test_single_word();
    do_reset();
    do_start();
    en_cnt = 0;
    sb.push_back('{addr: 15'd0, word: 16'hA5C3});
    send_bits(16'hA5C3, 16);
    e = sb.pop_front();
    total++;
    if ({word_valid_o, addr_o, word_o} !== {1'b1, e.addr, e.word}) begin
      bad++;
      $display("FAIL single_present got v=%0b a=%0d w=%h exp v=1 a=%0d w=%h",
               word_valid_o, addr_o, word_o, e.addr, e.word);
    end
    tick();
    total++;
    if ({word_valid_o, busy_o, addr_o} !== {1'b0, 1'b1, 15'd1}) begin
      bad++;
      $display("FAIL single_next got v=%0b b=%0b a=%0d exp v=0 b=1 a=1", word_valid_o, busy_o, addr_o);
    end
    tick(); tick();
    total++;
    if (en_cnt !== 16) begin
      bad++;
      $display("FAIL single_en_cycles got %0d exp 16", en_cnt);
    end
  endtask

  task automatic test_multi_word();
    logic [15:0] words [3];
    words[0] = 16'h0001; words[1] = 16'h8000; words[2] = 16'hFFFF;
    do_reset();
    do_start();
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{addr: AW'(k), word: words[k]});
      send_bits(words[k], 16);
      e = sb.pop_front();
      total++;
      if ({word_valid_o, addr_o, word_o} !== {1'b1, e.addr, e.word}) begin
        bad++;
        $display("FAIL multi_word%0d got v=%0b a=%0d w=%h exp v=1 a=%0d w=%h",
                 k, word_valid_o, addr_o, word_o, e.addr, e.word);
      end
      tick();
    end
    total++;
    if ({done_o, busy_o, word_valid_o, addr_o} !== {1'b1, 1'b0, 1'b0, 15'd2}) begin
      bad++;
      $display("FAIL multi_done got d=%0b b=%0b v=%0b a=%0d exp d=1 b=0 v=0 a=2",
               done_o, busy_o, word_valid_o, addr_o);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    do_start();
    word_ready_i = 1'b0;
    sb.push_back('{addr: 15'd0, word: 16'h5A5A});
    send_bits(16'h5A5A, 16);
    for (int c = 0; c < 5; c++) begin
      bit_valid_i = 1'b0;
      total++;
      if ({word_valid_o, word_o} !== {1'b1, 16'h5A5A}) begin
        bad++;
        $display("FAIL stall_hold%0d got v=%0b w=%h exp v=1 w=5a5a", c, word_valid_o, word_o);
      end
      if (c == 2) begin
        bit_valid_i = 1'b1;
        #1;
        total++;
        if (shift_en_o !== 1'b0) begin
          bad++;
          $display("FAIL stall_shift_en got %0b exp 0", shift_en_o);
        end
      end
      tick();
    end
    bit_valid_i = 1'b0;
    total++;
    if (overrun_o !== 1'b1) begin
      bad++;
      $display("FAIL stall_overrun got %0b exp 1", overrun_o);
    end
    e = sb.pop_front();
    total++;
    if ({word_valid_o, addr_o, word_o} !== {1'b1, e.addr, e.word}) begin
      bad++;
      $display("FAIL stall_accept got v=%0b a=%0d w=%h exp v=1 a=%0d w=%h",
               word_valid_o, addr_o, word_o, e.addr, e.word);
    end
    word_ready_i = 1'b1;
    tick();
    total++;
    if ({word_valid_o, busy_o, addr_o} !== {1'b0, 1'b1, 15'd1}) begin
      bad++;
      $display("FAIL stall_after got v=%0b b=%0b a=%0d exp v=0 b=1 a=1", word_valid_o, busy_o, addr_o);
    end
  endtask

  task automatic test_abort();
    send_bits(16'hFFFF, 7);
    abort_i = 1'b1;
    start_i = 1'b1;
    tick();
    abort_i = 1'b0;
    start_i = 1'b0;
    total++;
    if ({busy_o, word_valid_o, done_o, addr_o, overrun_o} !== {1'b0, 1'b0, 1'b0, 15'd0, 1'b1}) begin
      bad++;
      $display("FAIL abort_state got b=%0b v=%0b d=%0b a=%0d o=%0b exp b=0 v=0 d=0 a=0 o=1",
               busy_o, word_valid_o, done_o, addr_o, overrun_o);
    end
    do_start();
    sb.push_back('{addr: 15'd0, word: 16'h1234});
    send_bits(16'h1234, 16);
    e = sb.pop_front();
    total++;
    if ({word_valid_o, addr_o, word_o} !== {1'b1, e.addr, e.word}) begin
      bad++;
      $display("FAIL abort_restart got v=%0b a=%0d w=%h exp v=1 a=%0d w=%h",
               word_valid_o, addr_o, word_o, e.addr, e.word);
    end
    tick();
  endtask

  task automatic test_reset_in_present();
    do_reset();
    do_start();
    word_ready_i = 1'b0;
    sb.push_back('{addr: 15'd0, word: 16'hBEEF});
    send_bits(16'hBEEF, 16);
    bit_valid_i = 1'b1;
    tick();
    bit_valid_i = 1'b0;
    total++;
    if ({word_valid_o, overrun_o} !== 2'b11) begin
      bad++;
      $display("FAIL rst_pre got v=%0b o=%0b exp v=1 o=1", word_valid_o, overrun_o);
    end
    resetb = 1'b0;
    start_i = 1'b1;
    tick();
    total++;
    if ({word_valid_o, busy_o, done_o, overrun_o, addr_o} !== '0) begin
      bad++;
      $display("FAIL rst_present got v=%0b b=%0b d=%0b o=%0b a=%0d exp all 0",
               word_valid_o, busy_o, done_o, overrun_o, addr_o);
    end
    tick();
    resetb = 1'b1;
    start_i = 1'b0;
    tick();
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_start_ignored got busy=%0b exp 0", busy_o);
    end
    sb.delete();
    word_ready_i = 1'b1;
  endtask

  task automatic test_done_restart();
    logic [15:0] words [3];
    words[0] = 16'h0F0F; words[1] = 16'h3C3C; words[2] = 16'hC001;
    do_reset();
    do_start();
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{addr: AW'(k), word: words[k]});
      send_bits(words[k], 16);
      e = sb.pop_front();
      total++;
      if ({word_valid_o, addr_o, word_o} !== {1'b1, e.addr, e.word}) begin
        bad++;
        $display("FAIL restart_word%0d got v=%0b a=%0d w=%h exp v=1 a=%0d w=%h",
                 k, word_valid_o, addr_o, word_o, e.addr, e.word);
      end
      tick();
    end
    bit_valid_i = 1'b1;
    tick();
    bit_valid_i = 1'b0;
    total++;
    if ({done_o, overrun_o} !== 2'b11) begin
      bad++;
      $display("FAIL done_overrun got d=%0b o=%0b exp d=1 o=1", done_o, overrun_o);
    end
    start_i = 1'b1;
    bit_valid_i = 1'b1;
    #1;
    total++;
    if (shift_en_o !== 1'b0) begin
      bad++;
      $display("FAIL done_shift_en got %0b exp 0", shift_en_o);
    end
    tick();
    start_i = 1'b0;
    bit_valid_i = 1'b0;
    total++;
    if ({overrun_o, done_o, busy_o, addr_o} !== {1'b0, 1'b0, 1'b1, 15'd0}) begin
      bad++;
      $display("FAIL done_start got o=%0b d=%0b b=%0b a=%0d exp o=0 d=0 b=1 a=0",
               overrun_o, done_o, busy_o, addr_o);
    end
    sb.push_back('{addr: 15'd0, word: 16'h6789});
    send_bits(16'h6789, 16);
    e = sb.pop_front();
    total++;
    if ({word_valid_o, addr_o, word_o} !== {1'b1, e.addr, e.word}) begin
      bad++;
      $display("FAIL done_word0 got v=%0b a=%0d w=%h exp v=1 a=%0d w=%h",
               word_valid_o, addr_o, word_o, e.addr, e.word);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_word();
    test_multi_word();
    test_backpressure();
    test_abort();
    test_reset_in_present();
    test_done_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
